mp64_cpu_core: RTL and testbench



---
 rtl/mp64_cpu_core_pkg.sv | 64 ++++++
 rtl/mp64_cpu_core_alu.sv | 86 ++++++++
 rtl/mp64_cpu_core.sv | 133 +++++++++++++
 tb/tb_mp64_cpu_core.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp64_cpu_core_pkg.sv
// Shared definitions for the MP64 bring-up core: bus codes, FSM states,
// opcode families, ALU sub-ops and the flag register layout.
package mp64_cpu_core_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned NREGS  = 16;
  localparam int unsigned IBYTES = 3;

  localparam logic [1:0] BUS_BYTE  = 2'd0;
  localparam logic [1:0] BUS_HALF  = 2'd1;
  localparam logic [1:0] BUS_WORD  = 2'd2;
  localparam logic [1:0] BUS_DWORD = 2'd3;

  typedef enum logic [3:0] {
    ST_FETCH = 4'd0,
    ST_FWAIT = 4'd1,
    ST_EXEC  = 4'd2,
    ST_HALT  = 4'd7
  } state_t;

  localparam logic [3:0] FAM_SYS = 4'h0;
  localparam logic [3:0] FAM_INC = 4'h1;
  localparam logic [3:0] FAM_DEC = 4'h2;
  localparam logic [3:0] FAM_IMM = 4'h6;
  localparam logic [3:0] FAM_ALU = 4'h7;
  localparam logic [3:0] FAM_SEP = 4'hA;

  localparam logic [7:0] OP_HALT = 8'h02;
  localparam logic [7:0] OP_LDI  = 8'h60;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h2;
  localparam logic [3:0] ALU_AND = 4'h4;
  localparam logic [3:0] ALU_OR  = 4'h5;
  localparam logic [3:0] ALU_XOR = 4'h6;
  localparam logic [3:0] ALU_CMP = 4'h7;
  localparam logic [3:0] ALU_SHL = 4'hB;
  localparam logic [3:0] ALU_SHR = 4'hC;

  // Flag register layout, MSB first.
  typedef struct packed {
    logic s;
    logic i;
    logic g;
    logic p;
    logic v;
    logic n;
    logic c;
    logic z;
  } flags_t;

  // S and I are owned by software and survive ALU flag updates.
  localparam logic [7:0] FLAG_KEEP = 8'hC0;

  // Instruction length in bytes, decoded from the opcode byte.
  function automatic logic [1:0] insn_len(input logic [7:0] op);
    case (op[7:4])
      FAM_IMM: insn_len = 2'd3;
      FAM_ALU: insn_len = 2'd2;
      default: insn_len = 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/mp64_cpu_core_alu.sv
// Combinational register-register ALU: result, flag vector and the
// writeback / flag-update enables for one 0x7F sub-op.
module mp64_alu
  import mp64_cpu_core_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [3:0]  op,
  output logic [63:0] result_c,
  output logic [7:0]  flags_c,
  output logic        wen_c,
  output logic        flag_en_c
);

  logic [64:0] sum;
  logic [64:0] diff;
  logic [64:0] shl;
  logic [64:0] shr;
  logic [5:0]  amt;
  flags_t      f;

  assign amt  = b[5:0];
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  // The extra bit on each shifter catches the last bit shifted out.
  assign shl  = {1'b0, a} << amt;
  assign shr  = {a, 1'b0} >> amt;

  always_comb begin
    result_c  = '0;
    f         = '0;
    wen_c     = 1'b0;
    flag_en_c = 1'b0;
    case (op)
      ALU_ADD: begin
        result_c  = sum[63:0];
        f.c       = sum[64];
        f.v       = (a[63] == b[63]) && (sum[63] != a[63]);
        wen_c     = 1'b1;
        flag_en_c = 1'b1;
      end
      ALU_SUB, ALU_CMP: begin
        result_c  = diff[63:0];
        f.c       = diff[64];
        f.g       = !diff[64] && (diff[63:0] != '0);
        f.v       = (a[63] != b[63]) && (diff[63] != a[63]);
        wen_c     = (op == ALU_SUB);
        flag_en_c = 1'b1;
      end
      ALU_AND: begin
        result_c  = a & b;
        wen_c     = 1'b1;
        flag_en_c = 1'b1;
      end
      ALU_OR: begin
        result_c  = a | b;
        wen_c     = 1'b1;
        flag_en_c = 1'b1;
      end
      ALU_XOR: begin
        result_c  = a ^ b;
        wen_c     = 1'b1;
        flag_en_c = 1'b1;
      end
      ALU_SHL: begin
        result_c  = shl[63:0];
        f.c       = shl[64];
        wen_c     = 1'b1;
        flag_en_c = 1'b1;
      end
      ALU_SHR: begin
        result_c  = shr[64:1];
        f.c       = shr[0];
        wen_c     = 1'b1;
        flag_en_c = 1'b1;
      end
      default: ;
    endcase
    f.z = (result_c == '0);
    f.n = result_c[63];
    f.p = ~^result_c[7:0];
  end

  assign flags_c = f;

endmodule

// File: rtl/mp64_cpu_core.sv
// MP64 bring-up core: byte-serial fetch over the system bus, 16x64 register
// file with selectable PC, and NOP/HALT/INC/DEC/LDI/ALU/SEP execution.
module mp64_cpu_core
  import mp64_cpu_core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        bus_valid,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_wdata,
  output logic        bus_wen,
  output logic [1:0]  bus_size,
  input  logic [63:0] bus_rdata,
  input  logic        bus_ready,
  output logic        csr_wen,
  output logic [7:0]  csr_addr,
  output logic [63:0] csr_wdata,
  input  logic [63:0] csr_rdata,
  output logic        mex_valid,
  output logic [1:0]  mex_ss,
  output logic [1:0]  mex_op,
  output logic [2:0]  mex_funct,
  output logic [63:0] mex_gpr_val,
  output logic [7:0]  mex_imm8,
  input  logic        mex_done,
  input  logic        mex_busy,
  input  logic        irq_timer,
  input  logic        irq_uart,
  input  logic        irq_nic
);

  logic [XLEN-1:0] R [0:NREGS-1];
  logic [3:0]      psel;
  logic [7:0]      flags;
  state_t          cpu_state;
  logic [7:0]      ibuf [0:IBYTES-1];
  logic [1:0]      idx;

  logic [7:0]  cur_byte;
  logic [1:0]  ilen;
  logic [3:0]  rd;
  logic [3:0]  rs;
  logic [63:0] alu_result;
  logic [7:0]  alu_flags;
  logic        alu_wen;
  logic        alu_flag_en;
  logic        unused_inputs;

  // Length comes from the byte arriving now when it is the opcode itself.
  assign cur_byte = bus_rdata[7:0];
  assign ilen     = insn_len((idx == 2'd0) ? cur_byte : ibuf[0]);
  assign rd       = ibuf[1][7:4];
  assign rs       = ibuf[1][3:0];

  mp64_alu u_alu (
    .a         (R[rd]),
    .b         (R[rs]),
    .op        (ibuf[0][3:0]),
    .result_c  (alu_result),
    .flags_c   (alu_flags),
    .wen_c     (alu_wen),
    .flag_en_c (alu_flag_en)
  );

  assign bus_wdata   = '0;
  assign bus_wen     = 1'b0;
  assign bus_size    = BUS_BYTE;
  assign csr_wen     = 1'b0;
  assign csr_addr    = '0;
  assign csr_wdata   = '0;
  assign mex_valid   = 1'b0;
  assign mex_ss      = '0;
  assign mex_op      = '0;
  assign mex_funct   = '0;
  assign mex_gpr_val = '0;
  assign mex_imm8    = '0;

  assign unused_inputs = ^{bus_rdata[63:8], csr_rdata, mex_done, mex_busy,
                           irq_timer, irq_uart, irq_nic};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) R[i] <= '0;
      for (int i = 0; i < IBYTES; i++) ibuf[i] <= '0;
      psel      <= 4'd3;
      flags     <= '0;
      cpu_state <= ST_FETCH;
      idx       <= '0;
      bus_valid <= 1'b0;
      bus_addr  <= '0;
    end else begin
      bus_valid <= 1'b0;
      case (cpu_state)
        ST_FETCH: begin
          bus_valid <= 1'b1;
          bus_addr  <= R[psel];
          cpu_state <= ST_FWAIT;
        end
        ST_FWAIT: begin
          if (bus_ready) begin
            ibuf[idx] <= cur_byte;
            R[psel]   <= R[psel] + 64'd1;
            if (idx + 2'd1 < ilen) begin
              idx       <= idx + 2'd1;
              cpu_state <= ST_FETCH;
            end else begin
              cpu_state <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          idx       <= '0;
          cpu_state <= ST_FETCH;
          case (ibuf[0][7:4])
            FAM_SYS: if (ibuf[0] == OP_HALT) cpu_state <= ST_HALT;
            FAM_INC: R[ibuf[0][3:0]] <= R[ibuf[0][3:0]] + 64'd1;
            FAM_DEC: R[ibuf[0][3:0]] <= R[ibuf[0][3:0]] - 64'd1;
            FAM_IMM: if (ibuf[0] == OP_LDI) R[rd] <= 64'(ibuf[2]);
            FAM_ALU: begin
              if (alu_wen) R[rd] <= alu_result;
              if (alu_flag_en) flags <= alu_flags | (flags & FLAG_KEEP);
            end
            FAM_SEP: psel <= ibuf[0][3:0];
            default: ;
          endcase
        end
        ST_HALT: cpu_state <= ST_HALT;
        default: cpu_state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mp64_cpu_core.sv
// Bench for mp64_cpu_core: directed and random programs run against an
// instruction-level interpreter, with a random-latency byte memory.
module tb_mp64_cpu_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_valid;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic        bus_wen;
  logic [1:0]  bus_size;
  logic [63:0] bus_rdata = '0;
  logic        bus_ready = 1'b0;
  logic        csr_wen;
  logic [7:0]  csr_addr;
  logic [63:0] csr_wdata;
  logic [63:0] csr_rdata = '0;
  logic        mex_valid;
  logic [1:0]  mex_ss;
  logic [1:0]  mex_op;
  logic [2:0]  mex_funct;
  logic [63:0] mex_gpr_val;
  logic [7:0]  mex_imm8;
  logic        mex_done = 1'b0;
  logic        mex_busy = 1'b0;
  logic        irq_timer = 1'b0;
  logic        irq_uart = 1'b0;
  logic        irq_nic = 1'b0;

  always #5 clk = ~clk;

  mp64_cpu_core dut (
    .clk(clk), .rst(rst),
    .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wen(bus_wen), .bus_size(bus_size), .bus_rdata(bus_rdata),
    .bus_ready(bus_ready),
    .csr_wen(csr_wen), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata),
    .mex_valid(mex_valid), .mex_ss(mex_ss), .mex_op(mex_op),
    .mex_funct(mex_funct), .mex_gpr_val(mex_gpr_val), .mex_imm8(mex_imm8),
    .mex_done(mex_done), .mex_busy(mex_busy),
    .irq_timer(irq_timer), .irq_uart(irq_uart), .irq_nic(irq_nic)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:255];
  logic [7:0] prog [$];

  // Byte memory: answers each request 1..3 cycles later, watches the protocol.
  int         pulses;
  bit         proto_bad;
  bit         pend;
  int         lat;
  logic [7:0] pend_addr;
  bit         prev_valid;

  always @(negedge clk) begin
    bus_ready = 1'b0;
    if (rst) begin
      pend = 0; pulses = 0; proto_bad = 0; prev_valid = 0;
    end else begin
      if (pend) begin
        if (lat == 0) begin
          bus_ready = 1'b1;
          bus_rdata = {32'($urandom), 24'($urandom), mem[pend_addr]};
          pend = 0;
        end else lat--;
      end
      if (bus_valid) begin
        pulses++;
        if (prev_valid || pend) proto_bad = 1;
        pend = 1;
        lat = int'($urandom_range(0, 2));
        pend_addr = bus_addr[7:0];
      end
      prev_valid = bus_valid;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Instruction-level reference model.
  logic [63:0] m_r [16];
  logic [3:0]  m_psel;
  logic [7:0]  m_flags;
  int          m_fetches;
  bit          m_halted;

  task automatic m_fetch(output logic [7:0] b);
    b = mem[m_r[m_psel][7:0]];
    m_r[m_psel] = m_r[m_psel] + 64'd1;
    m_fetches++;
  endtask

  task automatic m_alu(input logic [3:0] f, input logic [3:0] rd, input logic [3:0] rs);
    logic [63:0] a, b, res;
    longint sa, sb, sr;
    int n;
    bit c, v, g, wb, known;
    a = m_r[rd]; b = m_r[rs]; n = int'(b[5:0]);
    sa = a; sb = b;
    c = 0; v = 0; g = 0; wb = 1; known = 1; res = '0;
    case (f)
      4'h0: begin
        res = a + b; sr = res;
        c = (res < a);
        v = ((sa < 0) == (sb < 0)) && ((sr < 0) != (sa < 0));
      end
      4'h2, 4'h7: begin
        res = a - b; sr = res;
        c = (a < b); g = (a > b);
        v = ((sa < 0) != (sb < 0)) && ((sr < 0) != (sa < 0));
        wb = (f == 4'h2);
      end
      4'h4: res = a & b;
      4'h5: res = a | b;
      4'h6: res = a ^ b;
      4'hB: begin res = a << n; c = (n == 0) ? 1'b0 : a[64-n]; end
      4'hC: begin res = a >> n; c = (n == 0) ? 1'b0 : a[n-1]; end
      default: known = 0;
    endcase
    if (known) begin
      if (wb) m_r[rd] = res;
      m_flags = {m_flags[7:6], g, ($countones(res[7:0]) % 2 == 0), v, res[63], c, (res == 0)};
    end
  endtask

  task automatic model_run();
    for (int i = 0; i < 16; i++) m_r[i] = '0;
    m_psel = 4'd3; m_flags = '0; m_fetches = 0; m_halted = 0;
    for (int step = 0; step < 2000 && !m_halted; step++) begin
      logic [7:0] op, b1, b2;
      b1 = '0; b2 = '0;
      m_fetch(op);
      if (op[7:4] == 4'h6) begin m_fetch(b1); m_fetch(b2); end
      else if (op[7:4] == 4'h7) m_fetch(b1);
      if (op == 8'h02) m_halted = 1;
      else if (op[7:4] == 4'h1) m_r[op[3:0]] = m_r[op[3:0]] + 64'd1;
      else if (op[7:4] == 4'h2) m_r[op[3:0]] = m_r[op[3:0]] - 64'd1;
      else if (op == 8'h60) m_r[b1[7:4]] = {56'd0, b2};
      else if (op[7:4] == 4'h7) m_alu(op[3:0], b1[7:4], b1[3:0]);
      else if (op[7:4] == 4'hA) m_psel = op[3:0];
    end
  endtask

  task automatic run_prog(input string name);
    int cyc;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < prog.size(); i++) mem[i] = prog[i];
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    while (dut.cpu_state !== 4'd7 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, " halted"}, 64'(dut.cpu_state), 64'd7);
    model_run();
    for (int i = 0; i < 16; i++) chk($sformatf("%s R%0d", name, i), dut.R[i], m_r[i]);
    chk({name, " psel"}, 64'(dut.psel), 64'(m_psel));
    chk({name, " flags"}, 64'(dut.flags), 64'(m_flags));
    chk({name, " fetch pulses"}, 64'(pulses), 64'(m_fetches));
    chk({name, " bus protocol"}, 64'(proto_bad), 64'd0);
  endtask

  function automatic logic [3:0] pick_reg();
    int unsigned x = $urandom_range(0, 14);
    return 4'(x >= 3 ? x + 1 : x);
  endfunction

  // Random program that never writes the PC register and ends in HALT.
  task automatic gen_random(input int n);
    prog.delete();
    repeat (n) begin
      logic [7:0] b;
      logic [3:0] r;
      int unsigned k;
      k = $urandom_range(0, 7);
      r = pick_reg();
      case (k)
        0: begin
          b = 8'($urandom);
          if (b[7:4] inside {4'h1, 4'h2, 4'h6, 4'h7, 4'hA} || b == 8'h02) b = 8'h01;
          prog.push_back(b);
        end
        1: prog.push_back({4'h1, r});
        2: prog.push_back({4'h2, r});
        3: begin
          prog.push_back(8'h60);
          prog.push_back({r, 4'($urandom)});
          prog.push_back(8'($urandom));
        end
        4: begin
          prog.push_back(8'(8'h61 + $urandom_range(0, 14)));
          prog.push_back(8'($urandom));
          prog.push_back(8'($urandom));
        end
        default: begin
          prog.push_back({4'h7, 4'($urandom)});
          prog.push_back({r, 4'($urandom)});
        end
      endcase
    end
    prog.push_back(8'h02);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset state", 64'(dut.cpu_state), 64'd0);
    chk("reset psel", 64'(dut.psel), 64'd3);
    chk("reset flags", 64'(dut.flags), 64'd0);
    chk("reset R3", dut.R[3], 64'd0);
    chk("reset bus_valid", 64'(bus_valid), 64'd0);
    chk("reset bus_addr", bus_addr, 64'd0);
    chk("idle outputs", 64'({bus_wen, bus_size, csr_wen, csr_addr, mex_valid,
                             mex_ss, mex_op, mex_funct, mex_imm8}), 64'd0);
    chk("idle wide outputs", bus_wdata | csr_wdata | mex_gpr_val, 64'd0);

    // 15 NOPs then HALT
    prog.delete();
    repeat (15) prog.push_back(8'h01);
    prog.push_back(8'h02);
    run_prog("nops");
    chk("nops pc", dut.R[3], 64'h10);

    prog = {8'h10, 8'h10, 8'h10, 8'h10, 8'h20, 8'h02};
    run_prog("incdec");
    chk("incdec R0", dut.R[0], 64'd3);

    prog = {8'h11, 8'h11, 8'h15, 8'h1F, 8'h02};
    run_prog("incmulti");
    chk("incmulti R1", dut.R[1], 64'd2);
    chk("incmulti R15", dut.R[15], 64'd1);

    prog = {8'h60, 8'h00, 8'h0A, 8'h60, 8'h10, 8'h14, 8'h70, 8'h01, 8'h02};
    run_prog("add");
    chk("add R0", dut.R[0], 64'd30);

    prog = {8'h60, 8'h00, 8'h05, 8'h60, 8'h10, 8'h05, 8'h72, 8'h01, 8'h02};
    run_prog("sub");
    chk("sub Z", 64'(dut.flags[0]), 64'd1);

    prog = {8'h60, 8'h00, 8'h0A, 8'h60, 8'h10, 8'h05, 8'h77, 8'h01, 8'h02};
    run_prog("cmp");
    chk("cmp R0", dut.R[0], 64'd10);
    chk("cmp G,Z", 64'({dut.flags[5], dut.flags[0]}), 64'b10);

    prog = {8'h60, 8'h00, 8'hFF, 8'h60, 8'h10, 8'h0F, 8'h74, 8'h01,
            8'h60, 8'h20, 8'hFF, 8'h75, 8'h21,
            8'h60, 8'h40, 8'hFF, 8'h76, 8'h41,
            8'h60, 8'h00, 8'h01, 8'h60, 8'h10, 8'h04, 8'h7B, 8'h01,
            8'h60, 8'h20, 8'h80, 8'h7C, 8'h21, 8'h02};
    run_prog("logic");
    chk("xor R4", dut.R[4], 64'hF0);
    chk("shl R0", dut.R[0], 64'd16);
    chk("shr R2", dut.R[2], 64'd8);

    prog = {8'h60, 8'h40, 8'h08, 8'hA4, 8'h02, 8'h00, 8'h00, 8'h00, 8'h10, 8'h02};
    run_prog("sep");
    chk("sep R0", dut.R[0], 64'd1);
    chk("sep psel", 64'(dut.psel), 64'd4);
    chk("sep R4", dut.R[4], 64'd10);

    for (int p = 0; p < 6; p++) begin
      gen_random(40);
      run_prog($sformatf("rand%0d", p));
    end

    // Reset in the middle of a running program
    gen_random(30);
    for (int i = 0; i < prog.size(); i++) mem[i] = prog[i];
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (23) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst state", 64'(dut.cpu_state), 64'd0);
    chk("midrst psel", 64'(dut.psel), 64'd3);
    chk("midrst R3", dut.R[3], 64'd0);
    chk("midrst flags", 64'(dut.flags), 64'd0);
    chk("midrst bus_valid", 64'(bus_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
